mem_port_arbiter: RTL and testbench

- Shares the softcore's single-port memory between the instruction-fetch requester (if_*) and the load/store requester (ls_*).
- Accepts one request at a time, latches it, drives the memory port until grant, waits for the response and routes it back to the owner.
- Provides fixed load/store priority with fetch anti-starvation.
- Drains and blocks traffic for a fence, acknowledging with fence_done.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_pick.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the single-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    FENCE = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  // Contested load/store wins tolerated before fetch is forced through.
  localparam int MAX_WAIT_DEFAULT = 4;

  // Width of the starvation counter; MAX_WAIT must fit (1..15).
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Fetch vs load/store pick logic with fetch anti-starvation counter.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   if_req,
  input  logic   ls_req,
  input  logic   enable,
  output owner_e winner,
  output logic   valid
);

  localparam logic [STARVE_W-1:0] MAX_CNT = STARVE_W'(MAX_WAIT);

  logic [STARVE_W-1:0] starve_cnt;
  logic                starved;

  assign starved = (starve_cnt == MAX_CNT);

  // Pick a winner: load/store has priority unless fetch has waited MAX_WAIT wins.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    winner = OWN_LS;
    valid  = 1'b0;
    if (enable) begin
      if (if_req && (!ls_req || starved)) begin
        winner = OWN_IF;
        valid  = 1'b1;
      end else if (ls_req) begin
        winner = OWN_LS;
        valid  = 1'b1;
      end
    end
  end

  // Count contested load/store wins; any fetch win or absent fetch request clears it.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      starve_cnt <= '0;
    end else if (enable) begin
      if (!if_req || (valid && winner == OWN_IF)) begin
        starve_cnt <= '0;
      end else if (valid && winner == OWN_LS && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with fence drain.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [DW/8-1:0] ls_be,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  input  logic          fence_req,
  output logic          fence_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  arb_state_e state;
  arb_state_e state_next;
  owner_e     owner;
  owner_e     pick_winner;
  logic       pick_valid;
  logic       pick_en;
  logic       fence_pend;
  logic       fence_hit;
  logic       resp_fire;

  // A pending or arriving fence blocks new grants; reset also forces grants low.
  assign fence_hit = fence_pend | fence_req;
  assign pick_en   = (state == IDLE) && !fence_hit && !reset;

  mem_arb_pick #(
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .clk    (clk),
    .reset  (reset),
    .if_req (if_req),
    .ls_req (ls_req),
    .enable (pick_en),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  assign if_gnt     = pick_valid && (pick_winner == OWN_IF);
  assign ls_gnt     = pick_valid && (pick_winner == OWN_LS);
  assign resp_fire  = (state == RESP) && mem_rvalid;
  assign if_rvalid  = resp_fire && (owner == OWN_IF);
  assign ls_rvalid  = resp_fire && (owner == OWN_LS);
  assign if_rdata   = if_rvalid ? mem_rdata : '0;
  assign ls_rdata   = ls_rvalid ? mem_rdata : '0;
  assign mem_req    = (state == REQ);
  assign fence_done = (state == FENCE);
  assign busy       = (state != IDLE) || fence_pend;

  // Next-state: grant, wait for memory accept, wait for response, then drain fences.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (fence_hit) begin
          state_next = FENCE;
        end else if (pick_valid) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_next = RESP;
        end
      end
      RESP: begin
        // Going straight to FENCE retires a waiting fence one cycle after the response.
        if (mem_rvalid) begin
          state_next = fence_hit ? FENCE : IDLE;
        end
      end
      FENCE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Fence capture in any state; a new fence in the FENCE cycle stays pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fence_pend <= 1'b0;
    end else if (fence_req) begin
      fence_pend <= 1'b1;
    end else if (state == FENCE) begin
      fence_pend <= 1'b0;
    end
  end

  // Latch the winner's request fields into the memory port registers on grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= OWN_IF;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (pick_valid) begin
      owner <= pick_winner;
      if (pick_winner == OWN_LS) begin
        mem_we    <= ls_we;
        mem_be    <= ls_be;
        mem_addr  <= ls_addr;
        mem_wdata <= ls_wdata;
      end else begin
        mem_we    <= 1'b0;
        mem_be    <= '1;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [3:0]    ls_be;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          fence_req;
  logic          fence_done;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int vectors;
  int miscompares;

  mem_port_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .MAX_WAIT (MW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_be      (ls_be),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_gnt     (ls_gnt),
    .ls_rvalid  (ls_rvalid),
    .ls_rdata   (ls_rdata),
    .fence_req  (fence_req),
    .fence_done (fence_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Start a new cycle just after the edge; single-cycle pulses return to 0.
  task automatic tick();
    @(posedge clk);
    #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    fence_req  = 1'b0;
  endtask

  // Let combinational outputs settle, sampling well before the next edge.
  task automatic settle();
    #3;
  endtask

  // Memory accepts next cycle and responds the cycle after; returns routing seen.
  task automatic serve_mem(input logic [DW-1:0] data, output logic got_if, output logic got_ls);
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    settle();
    got_if = if_rvalid;
    got_ls = ls_rvalid;
  endtask

  task automatic test_reset();
    if_req = 1'b1;
    ls_req = 1'b1;
    if_addr = 32'h1234;
    ls_addr = 32'h5678;
    #12;
    vectors++;
    if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, fence_done, mem_req, busy, mem_we} !== 8'h00)
      begin miscompares++; $display("FAIL reset_ctrl got=%b exp=00000000",
        {if_gnt, ls_gnt, if_rvalid, ls_rvalid, fence_done, mem_req, busy, mem_we}); end
    vectors++;
    if ({mem_be, mem_addr, mem_wdata, if_rdata, ls_rdata} !== 132'h0)
      begin miscompares++; $display("FAIL reset_data got=%h exp=0",
        {mem_be, mem_addr, mem_wdata, if_rdata, ls_rdata}); end
    if_req = 1'b0;
    ls_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    settle();
    vectors++;
    if ({if_gnt, ls_gnt, busy, mem_req, fence_done} !== 5'b0)
      begin miscompares++; $display("FAIL reset_release got=%b exp=00000",
        {if_gnt, ls_gnt, busy, mem_req, fence_done}); end
  endtask

  task automatic test_single_fetch();
    tick();
    if_req = 1'b1;
    if_addr = 32'h100;
    settle();
    vectors++;
    if ({if_gnt, ls_gnt, mem_req} !== 3'b100)
      begin miscompares++; $display("FAIL fetch_gnt got=%b exp=100", {if_gnt, ls_gnt, mem_req}); end
    tick();
    if_req = 1'b0;
    if_addr = 32'hFFFF_FFFF;
    mem_gnt = 1'b1;
    settle();
    vectors++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100})
      begin miscompares++; $display("FAIL fetch_req got=%h exp=%h",
        {mem_req, mem_we, mem_be, mem_addr}, {1'b1, 1'b0, 4'hF, 32'h100}); end
    tick();
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0000_0013;
    settle();
    vectors++;
    if ({if_rvalid, ls_rvalid, mem_req, if_rdata} !== {3'b100, 32'h13})
      begin miscompares++; $display("FAIL fetch_resp got=%h exp=%h",
        {if_rvalid, ls_rvalid, mem_req, if_rdata}, {3'b100, 32'h13}); end
    tick();
    settle();
    vectors++;
    if ({busy, if_rvalid} !== 2'b00)
      begin miscompares++; $display("FAIL fetch_idle got=%b exp=00", {busy, if_rvalid}); end
  endtask

  task automatic test_contention();
    tick();
    if_req = 1'b1; if_addr = 32'h200;
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h300;
    settle();
    vectors++;
    if ({if_gnt, ls_gnt} !== 2'b01)
      begin miscompares++; $display("FAIL contend_first got=%b exp=01", {if_gnt, ls_gnt}); end
    tick();
    ls_req = 1'b0;
    mem_gnt = 1'b1;
    settle();
    vectors++;
    if ({if_gnt, mem_addr} !== {1'b0, 32'h300})
      begin miscompares++; $display("FAIL contend_req got=%h exp=%h", {if_gnt, mem_addr}, {1'b0, 32'h300}); end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0001;
    settle();
    vectors++;
    if ({ls_rvalid, if_rvalid, if_gnt, ls_rdata} !== {3'b100, 32'hA5A5_0001})
      begin miscompares++; $display("FAIL contend_ls_resp got=%h exp=%h",
        {ls_rvalid, if_rvalid, if_gnt, ls_rdata}, {3'b100, 32'hA5A5_0001}); end
    tick();
    settle();
    vectors++;
    if ({if_gnt, ls_gnt} !== 2'b10)
      begin miscompares++; $display("FAIL contend_if_next got=%b exp=10", {if_gnt, ls_gnt}); end
    tick();
    if_req = 1'b0; mem_gnt = 1'b1;
    settle();
    vectors++;
    if (mem_addr !== 32'h200)
      begin miscompares++; $display("FAIL contend_if_addr got=%h exp=%h", mem_addr, 32'h200); end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    settle();
    vectors++;
    if ({if_rvalid, ls_rvalid, if_rdata} !== {2'b10, 32'h0BAD_F00D})
      begin miscompares++; $display("FAIL contend_if_resp got=%h exp=%h",
        {if_rvalid, ls_rvalid, if_rdata}, {2'b10, 32'h0BAD_F00D}); end
  endtask

  task automatic test_starvation();
    logic   got_if;
    logic   got_ls;
    logic   found;
    owner_e exp_w;
    for (int k = 0; k < 6; k++) begin
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
        tick();
        if_req = 1'b1; if_addr = 32'h400 + 32'(k);
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h800 + 32'(k);
        settle();
        if (if_gnt || ls_gnt) found = 1'b1;
      end
      exp_w = (k == MW) ? OWN_IF : OWN_LS;
      vectors++;
      if ({if_gnt, ls_gnt} !== ((exp_w == OWN_IF) ? 2'b10 : 2'b01))
        begin miscompares++; $display("FAIL starve_order[%0d] got=%b exp=%b", k,
          {if_gnt, ls_gnt}, (exp_w == OWN_IF) ? 2'b10 : 2'b01); end
      serve_mem(32'(k), got_if, got_ls);
      vectors++;
      if ({got_if, got_ls} !== ((exp_w == OWN_IF) ? 2'b10 : 2'b01))
        begin miscompares++; $display("FAIL starve_route[%0d] got=%b exp=%b", k,
          {got_if, got_ls}, (exp_w == OWN_IF) ? 2'b10 : 2'b01); end
    end
    tick();
    if_req = 1'b0;
    ls_req = 1'b0;
    settle();
  endtask

  task automatic test_stalled_store();
    tick();
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011;
    ls_addr = 32'h2004; ls_wdata = 32'hDEAD_BEEF;
    settle();
    vectors++;
    if (ls_gnt !== 1'b1)
      begin miscompares++; $display("FAIL store_gnt got=%b exp=1", ls_gnt); end
    for (int c = 0; c < 4; c++) begin
      tick();
      ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'hC;
      ls_addr = 32'h5555_5555; ls_wdata = 32'h1234_5678;
      mem_gnt = (c == 3);
      settle();
      vectors++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !==
          {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hDEAD_BEEF})
        begin miscompares++; $display("FAIL store_hold[%0d] got=%h exp=%h", c,
          {mem_req, mem_we, mem_be, mem_addr, mem_wdata},
          {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hDEAD_BEEF}); end
    end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0;
    settle();
    vectors++;
    if ({ls_rvalid, if_rvalid, mem_req} !== 3'b100)
      begin miscompares++; $display("FAIL store_resp got=%b exp=100", {ls_rvalid, if_rvalid, mem_req}); end
  endtask

  task automatic test_fence();
    // Fence arriving while a load waits for its response.
    tick();
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h40;
    settle();
    vectors++;
    if (ls_gnt !== 1'b1)
      begin miscompares++; $display("FAIL fence_ld_gnt got=%b exp=1", ls_gnt); end
    tick();
    ls_req = 1'b0; mem_gnt = 1'b1;
    tick();
    fence_req = 1'b1; if_req = 1'b1; if_addr = 32'h500;
    settle();
    vectors++;
    if ({if_gnt, fence_done} !== 2'b00)
      begin miscompares++; $display("FAIL fence_in_resp got=%b exp=00", {if_gnt, fence_done}); end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    settle();
    vectors++;
    if ({ls_rvalid, fence_done, if_gnt} !== 3'b100)
      begin miscompares++; $display("FAIL fence_n got=%b exp=100", {ls_rvalid, fence_done, if_gnt}); end
    tick();
    settle();
    vectors++;
    if ({fence_done, if_gnt, busy} !== 3'b101)
      begin miscompares++; $display("FAIL fence_n1 got=%b exp=101", {fence_done, if_gnt, busy}); end
    tick();
    settle();
    vectors++;
    if ({fence_done, if_gnt} !== 2'b01)
      begin miscompares++; $display("FAIL fence_n2 got=%b exp=01", {fence_done, if_gnt}); end
    tick();
    if_req = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_rvalid = 1'b1;
    settle();
    vectors++;
    if (if_rvalid !== 1'b1)
      begin miscompares++; $display("FAIL fence_if_resp got=%b exp=1", if_rvalid); end
    // Fence coinciding with a request in IDLE: the fence wins.
    tick();
    ls_req = 1'b1; ls_addr = 32'h80; fence_req = 1'b1;
    settle();
    vectors++;
    if ({ls_gnt, fence_done} !== 2'b00)
      begin miscompares++; $display("FAIL fence_tie0 got=%b exp=00", {ls_gnt, fence_done}); end
    tick();
    settle();
    vectors++;
    if ({ls_gnt, fence_done} !== 2'b01)
      begin miscompares++; $display("FAIL fence_tie1 got=%b exp=01", {ls_gnt, fence_done}); end
    tick();
    settle();
    vectors++;
    if ({ls_gnt, fence_done} !== 2'b10)
      begin miscompares++; $display("FAIL fence_tie2 got=%b exp=10", {ls_gnt, fence_done}); end
    tick();
    ls_req = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_rvalid = 1'b1;
    settle();
  endtask

  task automatic test_async_reset();
    tick();
    if_req = 1'b1; if_addr = 32'h900;
    settle();
    tick();
    if_req = 1'b0;
    settle();
    vectors++;
    if (mem_req !== 1'b1)
      begin miscompares++; $display("FAIL arst_pre got=%b exp=1", mem_req); end
    #1;
    reset = 1'b1;
    #1;
    vectors++;
    if ({mem_req, busy, if_gnt, ls_gnt, if_rvalid, ls_rvalid, fence_done, mem_addr} !== 39'h0)
      begin miscompares++; $display("FAIL arst_now got=%h exp=0",
        {mem_req, busy, if_gnt, ls_gnt, if_rvalid, ls_rvalid, fence_done, mem_addr}); end
    ls_req = 1'b1;
    #1;
    vectors++;
    if (ls_gnt !== 1'b0)
      begin miscompares++; $display("FAIL arst_gnt_gate got=%b exp=0", ls_gnt); end
    ls_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'hA00;
    settle();
    vectors++;
    if (ls_gnt !== 1'b1)
      begin miscompares++; $display("FAIL arst_after_gnt got=%b exp=1", ls_gnt); end
    tick();
    ls_req = 1'b0; mem_gnt = 1'b1;
    settle();
    vectors++;
    if ({mem_req, mem_addr} !== {1'b1, 32'hA00})
      begin miscompares++; $display("FAIL arst_after_req got=%h exp=%h", {mem_req, mem_addr}, {1'b1, 32'hA00}); end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h5;
    settle();
    vectors++;
    if ({ls_rvalid, ls_rdata} !== {1'b1, 32'h5})
      begin miscompares++; $display("FAIL arst_after_resp got=%h exp=%h", {ls_rvalid, ls_rdata}, {1'b1, 32'h5}); end
    tick();
    settle();
  endtask

  // Random traffic against a transaction-level model: phase 0 = nothing outstanding,
  // 1 = waiting for memory accept, 2 = waiting for memory response.
  task automatic test_random();
    int          phase;
    bit          pend;
    bit          pend_start;
    bit          fence_now;
    int          contested;
    owner_e      cur_owner;
    owner_e      exp_w;
    logic [1:0]  exp_g;
    logic [68:0] exp_fields;
    bit          drop_if;
    bit          drop_ls;
    phase = 0; pend = 1'b0; contested = 0; cur_owner = OWN_IF;
    exp_fields = '0; drop_if = 1'b0; drop_ls = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (drop_if) if_req = 1'b0;
      if (drop_ls) ls_req = 1'b0;
      drop_if = 1'b0;
      drop_ls = 1'b0;
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (!ls_req && $urandom_range(0, 3) == 0) begin
        ls_req = 1'b1; ls_we = 1'($urandom_range(0, 1)); ls_be = 4'($urandom_range(0, 15));
        ls_addr = $urandom; ls_wdata = $urandom;
      end
      fence_now = !pend && ($urandom_range(0, 19) == 0);
      fence_req = fence_now;
      mem_gnt = 1'($urandom_range(0, 1));
      mem_rvalid = (phase == 2) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
      settle();

      pend_start = pend;
      if (fence_now) pend = 1'b1;

      vectors++;
      if (mem_req !== (phase == 1))
        begin miscompares++; $display("FAIL rnd_mem_req cyc=%0d got=%b exp=%b", cyc, mem_req, phase == 1); end
      if (phase == 1) begin
        vectors++;
        if ({mem_we, mem_be, mem_addr, mem_wdata} !== exp_fields)
          begin miscompares++; $display("FAIL rnd_fields cyc=%0d got=%h exp=%h", cyc,
            {mem_we, mem_be, mem_addr, mem_wdata}, exp_fields); end
      end
      vectors++;
      if ({if_rvalid, ls_rvalid} !== {phase == 2 && mem_rvalid && cur_owner == OWN_IF,
                                      phase == 2 && mem_rvalid && cur_owner == OWN_LS})
        begin miscompares++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, {if_rvalid, ls_rvalid},
          {phase == 2 && mem_rvalid && cur_owner == OWN_IF, phase == 2 && mem_rvalid && cur_owner == OWN_LS}); end
      if (phase == 2 && mem_rvalid) begin
        vectors++;
        if (((cur_owner == OWN_IF) ? if_rdata : ls_rdata) !== mem_rdata)
          begin miscompares++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc,
            (cur_owner == OWN_IF) ? if_rdata : ls_rdata, mem_rdata); end
      end
      vectors++;
      if (fence_done !== (pend_start && phase == 0))
        begin miscompares++; $display("FAIL rnd_fence_done cyc=%0d got=%b exp=%b", cyc,
          fence_done, pend_start && phase == 0); end
      vectors++;
      if (busy !== (phase != 0 || pend_start))
        begin miscompares++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, phase != 0 || pend_start); end

      exp_g = 2'b00;
      exp_w = OWN_LS;
      if (phase == 0 && !pend && (if_req || ls_req)) begin
        exp_w = (if_req && (!ls_req || contested == MW)) ? OWN_IF : OWN_LS;
        exp_g = (exp_w == OWN_IF) ? 2'b10 : 2'b01;
      end
      vectors++;
      if ({if_gnt, ls_gnt} !== exp_g)
        begin miscompares++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b cont=%0d", cyc,
          {if_gnt, ls_gnt}, exp_g, contested); end

      if (pend_start && phase == 0) pend = fence_now;
      if (exp_g != 2'b00) begin
        cur_owner = exp_w;
        if (exp_w == OWN_IF) begin
          contested = 0;
          exp_fields = {1'b0, 4'hF, if_addr, 32'h0};
          drop_if = 1'b1;
        end else begin
          if (if_req) contested++;
          exp_fields = {ls_we, ls_be, ls_addr, ls_wdata};
          drop_ls = 1'b1;
        end
        phase = 1;
      end else if (phase == 1 && mem_gnt) begin
        phase = 2;
      end else if (phase == 2 && mem_rvalid) begin
        phase = 0;
      end
    end
    tick();
    if_req = 1'b0;
    ls_req = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
    fence_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_starvation();
    test_stalled_store();
    test_fence();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
